// File: rtl/conv_stream_layer.sv
// conv_stream_layer: streaming KxK valid convolution over a raster pixel stream with line buffers, stride and optional ReLU
module conv_stream_layer #(
  parameter int    DATA_WIDTH  = 8,
  parameter int    KDATA_WIDTH = 8,
  parameter int    KERNEL_SIZE = 3,
  parameter int    IMGCOL      = 7,
  parameter int    IMGROW      = 7,
  parameter int    STRIDE      = 1,
  parameter string ACTIVATION  = "RELU",
  parameter int    OUT_WIDTH   = DATA_WIDTH + KDATA_WIDTH + $clog2(KERNEL_SIZE * KERNEL_SIZE)
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       kernel_wr_en,
  input  logic [$clog2(KERNEL_SIZE*KERNEL_SIZE)-1:0] kernel_wr_addr,
  input  logic signed [KDATA_WIDTH-1:0]              kernel_wr_data,
  input  logic                                       pix_valid,
  output logic                                       pix_ready,
  input  logic signed [DATA_WIDTH-1:0]               pix_data,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic signed [OUT_WIDTH-1:0]                out_data,
  output logic                                       out_last,
  output logic                                       busy
);
  localparam int K      = KERNEL_SIZE;
  localparam int KK     = K * K;
  localparam int CW     = $clog2(IMGCOL);
  localparam int RW     = $clog2(IMGROW);
  localparam int PW     = DATA_WIDTH + KDATA_WIDTH;
  localparam int LAST_R = K - 1 + ((IMGROW - K) / STRIDE) * STRIDE;
  localparam int LAST_C = K - 1 + ((IMGCOL - K) / STRIDE) * STRIDE;
  localparam bit RELU   = (ACTIVATION == "RELU");

  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic signed [DATA_WIDTH-1:0]  lb [K-1][IMGCOL];
  logic signed [DATA_WIDTH-1:0]  win [K][K];
  logic signed [DATA_WIDTH-1:0]  colv [K];
  logic signed [KDATA_WIDTH-1:0] kern [KK];
  logic signed [PW-1:0]          prod [KK];
  logic signed [OUT_WIDTH-1:0]   sum, act;
  logic [31:0] r_off, c_off;
  logic en, acc, start, emit, last_win, col_end, row_end;
  logic v1, l1, v2, l2;

  assign en        = !out_valid || out_ready;
  assign pix_ready = en;
  assign acc       = pix_valid && en;
  assign start     = acc && row == '0 && col == '0;
  assign col_end   = col == CW'(IMGCOL - 1);
  assign row_end   = row == RW'(IMGROW - 1);
  assign r_off     = 32'(row) - 32'(K - 1);
  assign c_off     = 32'(col) - 32'(K - 1);
  assign emit      = row >= RW'(K - 1) && col >= CW'(K - 1) &&
                     (r_off % 32'(STRIDE)) == 32'd0 && (c_off % 32'(STRIDE)) == 32'd0;
  assign last_win  = row == RW'(LAST_R) && col == CW'(LAST_C);

  // New window column, oldest row first: line buffers then the incoming pixel
  always_comb begin
    for (int i = 0; i < K - 1; i++) colv[i] = lb[K-2-i][col];
    colv[K-1] = pix_data;
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      lb[0][col] <= pix_data;
      for (int i = 1; i < K - 1; i++) lb[i][col] <= lb[i-1][col];
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K - 1; j++) win[i][j] <= win[i][j+1];
        win[i][K-1] <= colv[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en)
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++)
          prod[i*K+j] <= PW'(win[i][j]) * PW'(kern[i*K+j]);
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < KK; k++) sum = sum + OUT_WIDTH'(prod[k]);
  end

  assign act = (RELU && sum[OUT_WIDTH-1]) ? '0 : sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row       <= '0;
      col       <= '0;
      v1        <= 1'b0;
      l1        <= 1'b0;
      v2        <= 1'b0;
      l2        <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      for (int k = 0; k < KK; k++) kern[k] <= '0;
    end else begin
      // Kernel is frozen from the first accepted pixel until the last result leaves
      if (kernel_wr_en && !busy && !start && int'(kernel_wr_addr) < KK)
        kern[kernel_wr_addr] <= kernel_wr_data;
      busy <= start ? 1'b1 : (out_valid && out_ready && out_last) ? 1'b0 : busy;
      if (acc) begin
        col <= col_end ? '0 : col + 1'b1;
        row <= col_end ? (row_end ? '0 : row + 1'b1) : row;
      end
      if (en) begin
        v1        <= acc && emit;
        l1        <= acc && emit && last_win;
        v2        <= v1;
        l2        <= l1;
        out_valid <= v2;
        out_last  <= l2;
        if (v2) out_data <= act;
      end
    end
  end
endmodule

// File: tb/tb_conv_stream_layer.sv
// tb_conv_stream_layer: directed checks of conv_stream_layer across NONE/RELU activation and stride 1/2
module tb_conv_stream_layer;
  logic clk = 1'b0;
  logic rst;
  logic kernel_wr_en;
  logic [3:0] kernel_wr_addr;
  logic signed [7:0] kernel_wr_data, pix_data;
  logic [2:0] pv, ordy;
  wire  [2:0] prdy, ov, ol, bsy;
  wire  signed [19:0] od [3];
  int tests = 0, fails = 0, cyc = 0;
  logic clr = 1'b0;
  int cnt [3], acc_n [3], acc0 [3];
  int rd [3][64], rp [3][64];
  logic rl [3][64];
  logic signed [7:0] img [49];

  always #5 clk = ~clk;

  conv_stream_layer #(.ACTIVATION("NONE")) u_n (
    .clk(clk), .rst(rst), .kernel_wr_en(kernel_wr_en), .kernel_wr_addr(kernel_wr_addr),
    .kernel_wr_data(kernel_wr_data), .pix_valid(pv[0]), .pix_ready(prdy[0]), .pix_data(pix_data),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .out_last(ol[0]), .busy(bsy[0]));
  conv_stream_layer u_r (
    .clk(clk), .rst(rst), .kernel_wr_en(kernel_wr_en), .kernel_wr_addr(kernel_wr_addr),
    .kernel_wr_data(kernel_wr_data), .pix_valid(pv[1]), .pix_ready(prdy[1]), .pix_data(pix_data),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .out_last(ol[1]), .busy(bsy[1]));
  conv_stream_layer #(.STRIDE(2)) u_s (
    .clk(clk), .rst(rst), .kernel_wr_en(kernel_wr_en), .kernel_wr_addr(kernel_wr_addr),
    .kernel_wr_data(kernel_wr_data), .pix_valid(pv[2]), .pix_ready(prdy[2]), .pix_data(pix_data),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]), .out_last(ol[2]), .busy(bsy[2]));

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (clr) begin
        cnt[d] = 0;
        acc_n[d] = 0;
      end else begin
        if (pv[d] && prdy[d]) begin
          if (acc_n[d] == 0) acc0[d] = cyc + 1;
          acc_n[d]++;
        end
        if (ov[d] && ordy[d]) begin
          if (cnt[d] < 64) begin
            rd[d][cnt[d]] = od[d];
            rl[d][cnt[d]] = ol[d];
            rp[d][cnt[d]] = cyc - acc0[d] - 2;
          end
          cnt[d]++;
        end
      end
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr_k(input int a, input int v);
    kernel_wr_en = 1'b1;
    kernel_wr_addr = 4'(a);
    kernel_wr_data = 8'(v);
    tick();
    kernel_wr_en = 1'b0;
  endtask

  task automatic load_k(input bit ones);
    logic signed [7:0] kt [9];
    kt = '{8'sh02, 8'shF2, 8'sh01, 8'shFC, 8'shFE, 8'sh01, 8'shFC, 8'shFE, 8'sh01};
    for (int i = 0; i < 9; i++) wr_k(i, ones ? 1 : int'(kt[i]));
  endtask

  task automatic set_img(input bit ones);
    logic signed [7:0] top [9];
    top = '{8'shFE, 8'sh04, 8'shFF, 8'sh04, 8'sh01, 8'shFF, 8'sh01, 8'sh06, 8'shFF};
    for (int i = 0; i < 49; i++) img[i] = ones ? 8'sd1 : 8'sd0;
    if (!ones)
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) img[r*7+c] = top[r*3+c];
  endtask

  task automatic clear;
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic drain;
    repeat (6) tick();
  endtask

  task automatic stall(input int d);
    int d0, l0;
    ordy[d] = 1'b0;
    @(negedge clk);
    check("stall_pending", ov[d], 1);
    d0 = od[d];
    l0 = ol[d];
    repeat (10) begin
      @(negedge clk);
      check("stall_pix_ready", prdy[d], 0);
      check("stall_valid", ov[d], 1);
      check("stall_data", od[d], d0);
      check("stall_last", ol[d], l0);
    end
    tick();
    ordy[d] = 1'b1;
  endtask

  task automatic stream(input int d, input int n, input int stall_at, input int wr_at);
    int t;
    for (int i = 0; i < n; i++) begin
      pix_data = img[i];
      pv[d] = 1'b1;
      if (i == wr_at) begin
        check("busy_mid", bsy[d], 1);
        kernel_wr_en = 1'b1;
        kernel_wr_addr = 4'd4;
        kernel_wr_data = 8'sh7F;
      end
      if (i == stall_at) stall(d);
      t = 0;
      @(negedge clk);
      while (!prdy[d] && t < 100) begin
        t++;
        @(negedge clk);
      end
      if (t >= 100) check("pix_timeout", 0, 1);
      tick();
      kernel_wr_en = 1'b0;
    end
    pv[d] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    pv = '0;
    ordy = '1;
    kernel_wr_en = 1'b0;
    kernel_wr_addr = '0;
    kernel_wr_data = '0;
    pix_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", ov[0], 0);
    check("rst_last", ol[0], 0);
    check("rst_busy", bsy[0], 0);
    check("rst_data", od[0], 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rdy_after_rst", prdy[0], 1);
    tick();

    load_k(1'b0);
    set_img(1'b0);
    clear();
    stream(0, 49, -1, -1);
    drain();
    check("none_first", rd[0][0], -97);
    check("none_second", rd[0][1], -2);
    check("none_cnt", cnt[0], 25);
    stream(1, 49, -1, -1);
    drain();
    check("relu_first", rd[1][0], 0);
    check("relu_third", rd[1][2], 6);

    load_k(1'b1);
    set_img(1'b1);
    clear();
    stream(1, 49, 20, -1);
    drain();
    check("s1_cnt", cnt[1], 25);
    check("s1_latency", rp[1][0], 16);
    check("s1_busy_end", bsy[1], 0);
    for (int k = 0; k < 25; k++) begin
      check("s1_val", rd[1][k], 9);
      check("s1_last", int'(rl[1][k]), int'(k == 24));
    end

    stream(2, 49, -1, -1);
    drain();
    check("s2_cnt", cnt[2], 9);
    for (int k = 0; k < 9; k++) begin
      check("s2_val", rd[2][k], 9);
      check("s2_last", int'(rl[2][k]), int'(k == 8));
      check("s2_pixel", rp[2][k], (2 + 2 * (k / 3)) * 7 + 2 + 2 * (k % 3));
    end

    clear();
    stream(0, 49, -1, 10);
    drain();
    check("busy_wr_cnt", cnt[0], 25);
    check("busy_wr_first", rd[0][0], 9);
    check("busy_wr_lastval", rd[0][24], 9);
    check("busy_wr_idle", bsy[0], 0);
    wr_k(4, 8'sh7F);
    clear();
    stream(0, 49, -1, -1);
    drain();
    check("idle_wr_cnt", cnt[0], 25);
    check("idle_wr_first", rd[0][0], 135);
    check("idle_wr_lastval", rd[0][24], 135);

    clear();
    stream(0, 20, -1, -1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", ov[0], 0);
    check("midrst_busy", bsy[0], 0);
    tick();
    rst = 1'b0;
    clear();
    stream(0, 49, -1, -1);
    drain();
    check("midrst_cnt", cnt[0], 25);
    for (int k = 0; k < 25; k++) check("midrst_val", rd[0][k], 0);
    check("midrst_last", int'(rl[0][24]), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
